// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
//
// Purpose:
//   OAM DMA controller sitting between the SM83 core bus and the shared
//   single-write-port memory.  A CPU write to the DMA register latches a
//   source page and copies NUM_BYTES bytes from {page,00} to 0xFE00, one byte
//   per CYC_PER_BYTE clocks, after a START_DELAY clock lead-in.  While a
//   transfer is running the CPU may only reach HRAM (0xFF80-0xFFFE) and the
//   DMA register, and only on cycles where the DMA is not copying.  When idle
//   the block is a transparent pass-through.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   cpu_rd_addr  in   CPU read address
//   cpu_rd_data  out  CPU read data (combinational)
//   cpu_wen      in   CPU write enable
//   cpu_wr_addr  in   CPU write address
//   cpu_wr_data  in   CPU write data
//   mem_r_addr   out  memory read address
//   mem_r_data   in   memory read data (combinational)
//   mem_wen      out  memory write enable
//   mem_w_addr   out  memory write address
//   mem_w_data   out  memory write data
//   dma_active   out  high while a transfer is starting or running
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter int          CYC_PER_BYTE = 4,
    parameter int          START_DELAY  = 4,
    parameter int          NUM_BYTES    = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_rd_addr,
    output logic [7:0]  cpu_rd_data,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_wr_addr,
    input  logic [7:0]  cpu_wr_data,
    output logic [15:0] mem_r_addr,
    input  logic [7:0]  mem_r_data,
    output logic        mem_wen,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    output logic        dma_active
);

    localparam int DIV_W = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
    localparam int CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYC_PER_BYTE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_XFER
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_dma_reg;
    logic [7:0]       w_dma_reg_nxt;
    logic [7:0]       r_src_page;
    logic [7:0]       w_src_page_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [7:0]       r_byte_idx;
    logic [7:0]       w_byte_idx_nxt;

    logic             w_reg_wr;
    logic             w_active;
    logic             w_copy;
    logic             w_rd_hram;
    logic             w_wr_hram;
    logic             w_rd_reg;
    logic [7:0]       w_src_map;

    // Decode of the current cycle: register writes, the copy slot, and which
    // CPU addresses remain reachable while the DMA owns the bus.
    assign w_reg_wr   = cpu_wen && (cpu_wr_addr == DMA_REG_ADDR);
    assign w_active   = (r_state != ST_IDLE);
    assign w_copy     = (r_state == ST_XFER) && (r_div == DIV_LAST);
    assign w_rd_hram  = (cpu_rd_addr >= 16'hFF80) && (cpu_rd_addr <= 16'hFFFE);
    assign w_wr_hram  = (cpu_wr_addr >= 16'hFF80) && (cpu_wr_addr <= 16'hFFFE);
    assign w_rd_reg   = (cpu_rd_addr == DMA_REG_ADDR);
    assign dma_active = w_active;

    // Pages E0-FF are echo RAM, so fold them back onto C0-DF.
    assign w_src_map = (cpu_wr_data >= 8'hE0) ? (cpu_wr_data - 8'h20) : cpu_wr_data;

    // State register.  Reset aborts any transfer immediately; whatever bytes
    // were already committed to memory simply stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dma_reg  <= 8'hFF;
            r_src_page <= 8'h00;
            r_cnt      <= '0;
            r_div      <= '0;
            r_byte_idx <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_dma_reg  <= w_dma_reg_nxt;
            r_src_page <= w_src_page_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

    // Next-state logic.  A register write overrides whatever the sequencer
    // was doing, which gives restart-on-write; a copy slot coinciding with
    // that write still commits its byte because the memory port outputs are
    // decided from the current state, not the next one.
    always_comb begin
        w_state_nxt    = r_state;
        w_dma_reg_nxt  = r_dma_reg;
        w_src_page_nxt = r_src_page;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div;
        w_byte_idx_nxt = r_byte_idx;

        case (r_state)
            ST_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_XFER;
                    w_div_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_XFER: begin
                if (w_copy) begin
                    w_div_nxt = '0;
                    if (r_byte_idx == IDX_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_byte_idx_nxt = 8'h00;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 8'h01;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (w_reg_wr) begin
            w_dma_reg_nxt  = cpu_wr_data;
            w_src_page_nxt = w_src_map;
            w_state_nxt    = ST_START;
            w_cnt_nxt      = '0;
            w_div_nxt      = '0;
            w_byte_idx_nxt = 8'h00;
        end
    end

    // Memory read address: the DMA source during a copy slot, otherwise the
    // CPU address.  Kept apart from the read-data mux so the memory's
    // combinational read path does not loop back through one process.
    always_comb begin
        mem_r_addr = cpu_rd_addr;
        if (w_copy) begin
            mem_r_addr = {r_src_page, r_byte_idx};
        end
    end

    // CPU read data.  During a transfer only HRAM and the DMA register are
    // visible, and nothing is visible on a copy slot because the DMA owns the
    // read port then.
    always_comb begin
        cpu_rd_data = mem_r_data;
        if (w_copy) begin
            cpu_rd_data = 8'hFF;
        end else if (w_rd_reg) begin
            cpu_rd_data = r_dma_reg;
        end else if (w_active && !w_rd_hram) begin
            cpu_rd_data = 8'hFF;
        end
    end

    // Memory write port.  The copy slot always wins; otherwise CPU writes pass
    // through (all of them when idle, HRAM only when busy), and the DMA
    // register itself never reaches memory.
    always_comb begin
        mem_wen    = 1'b0;
        mem_w_addr = cpu_wr_addr;
        mem_w_data = cpu_wr_data;
        if (w_copy) begin
            mem_wen    = 1'b1;
            mem_w_addr = {8'hFE, r_byte_idx};
            mem_w_data = mem_r_data;
        end else if (w_active) begin
            mem_wen = cpu_wen && w_wr_hram;
        end else begin
            mem_wen = cpu_wen && !w_reg_wr;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Directed bench for oam_dma_ctrl.  A 64 KiB byte memory model sits on the
// memory side.  Inputs change on the falling edge and outputs are sampled
// shortly after, so the rising edge always sees stable values.
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_rd_addr;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wen;
    logic [15:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic [15:0] mem_r_addr;
    logic [7:0]  mem_r_data;
    logic        mem_wen;
    logic [15:0] mem_w_addr;
    logic [7:0]  mem_w_data;
    logic        dma_active;

    logic [7:0]  mem [0:65535];

    int          total;
    int          bad;
    int          len;

    oam_dma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd_addr (cpu_rd_addr),
        .cpu_rd_data (cpu_rd_data),
        .cpu_wen     (cpu_wen),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .mem_wen     (mem_wen),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .dma_active  (dma_active)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Initial memory image: copy sources at C000, C100 and D000, a marker in
    // the OAM area, and a marker at the DMA register address to prove the
    // register write never lands in memory.
    function automatic logic [7:0] initVal(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        if (a >= 16'hC000 && a < 16'hC0A0) return lo ^ 8'h5A;
        if (a >= 16'hC100 && a < 16'hC1A0) return lo + 8'h40;
        if (a >= 16'hD000 && a < 16'hD0A0) return ~lo;
        if (a >= 16'hFE00 && a < 16'hFEA0) return 8'hEE;
        if (a == 16'hFF46)                 return 8'h77;
        return 8'h00;
    endfunction

    // Memory model: combinational read, write on the rising edge.
    assign mem_r_data = mem[mem_r_addr];

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = initVal(16'(a));
        forever begin
            @(posedge clk);
            if (mem_wen) mem[mem_w_addr] = mem_w_data;
        end
    end

    // One comparison: count it, and on a miss count and report it.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive all CPU-side inputs at once.
    task automatic applyStimulus(input logic wen, input logic [15:0] waddr,
                                 input logic [7:0] wdata, input logic [15:0] raddr);
        cpu_wen     = wen;
        cpu_wr_addr = waddr;
        cpu_wr_data = wdata;
        cpu_rd_addr = raddr;
    endtask

    // Single-cycle CPU write: called on a falling edge, sampled on the next
    // rising edge, returns on the following falling edge with cpu_wen low.
    task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, addr, data, cpu_rd_addr);
        @(negedge clk);
        cpu_wen = 1'b0;
    endtask

    // Count cycles with dma_active high, starting with the current one.
    task automatic waitIdle(output int n);
        n = 0;
        while (dma_active === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 16'h0000, 8'h00, 16'hFF46);

        // Reset state
        #1;
        checkOutput("rst_active", {15'd0, dma_active}, 16'h0000);
        checkOutput("rst_wen", {15'd0, mem_wen}, 16'h0000);
        checkOutput("rst_reg", {8'd0, cpu_rd_data}, 16'h00FF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full copy from page C0; the register write must not reach memory
        applyStimulus(1'b1, 16'hFF46, 8'hC0, 16'hFF46);
        #1;
        checkOutput("regwr_wen", {15'd0, mem_wen}, 16'h0000);
        @(negedge clk);
        cpu_wen = 1'b0;
        waitIdle(len);
        checkOutput("full_len", 16'(len), 16'd644);
        for (int i = 0; i < 160; i++)
            checkOutput($sformatf("full_fe%0h", i), {8'd0, mem[16'hFE00 + 16'(i)]},
                        {8'd0, 8'(i) ^ 8'h5A});
        cpu_rd_addr = 16'hFF46;
        #1;
        checkOutput("full_reg", {8'd0, cpu_rd_data}, 16'h00C0);
        checkOutput("full_ff46mem", {8'd0, mem[16'hFF46]}, 16'h0077);
        @(negedge clk);

        // CPU lockout during a transfer (cycle k after the write edge;
        // copy slots are k = 7, 11, 15, ...)
        cpuWrite(16'hFF46, 8'hC0);
        repeat (8) @(negedge clk);
        applyStimulus(1'b1, 16'hC100, 8'h33, 16'hC000);
        #1;
        checkOutput("lock_rd_c000", {8'd0, cpu_rd_data}, 16'h00FF);
        checkOutput("lock_wen_c100", {15'd0, mem_wen}, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b1, 16'hFF80, 8'h12, 16'hC000);
        #1;
        checkOutput("lock_wen_ff80", {15'd0, mem_wen}, 16'h0001);
        @(negedge clk);
        applyStimulus(1'b0, 16'hFF80, 8'h00, 16'hFF80);
        #1;
        checkOutput("lock_rd_ff80", {8'd0, cpu_rd_data}, 16'h0012);
        @(negedge clk);
        applyStimulus(1'b1, 16'hFF81, 8'h55, 16'hFF80);
        #1;
        checkOutput("copy_rd_ff80", {8'd0, cpu_rd_data}, 16'h00FF);
        checkOutput("copy_wen", {15'd0, mem_wen}, 16'h0001);
        checkOutput("copy_waddr", mem_w_addr, 16'hFE01);
        checkOutput("copy_wdata", {8'd0, mem_w_data}, 16'h005B);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 8'h00, 16'h0000);
        checkOutput("lock_ff81", {8'd0, mem[16'hFF81]}, 16'h0000);
        checkOutput("lock_c100", {8'd0, mem[16'hC100]}, 16'h0040);
        checkOutput("lock_ff80", {8'd0, mem[16'hFF80]}, 16'h0012);
        waitIdle(len);
        checkOutput("lock_len", 16'(len), 16'd632);

        // Restart with page D0 two clocks after byte 50 commits
        cpuWrite(16'hFF46, 8'hC0);
        repeat (209) @(negedge clk);
        checkOutput("rs_byte50", {8'd0, mem[16'hFE32]}, 16'h0068);
        cpuWrite(16'hFF46, 8'hD0);
        waitIdle(len);
        checkOutput("rs_len", 16'(len), 16'd644);
        for (int i = 0; i < 160; i++)
            checkOutput($sformatf("rs_fe%0h", i), {8'd0, mem[16'hFE00 + 16'(i)]},
                        {8'd0, ~8'(i)});

        // Echo page E1 maps to C1
        cpuWrite(16'hFF46, 8'hE1);
        waitIdle(len);
        checkOutput("echo_len", 16'(len), 16'd644);
        for (int i = 0; i < 160; i++)
            checkOutput($sformatf("echo_fe%0h", i), {8'd0, mem[16'hFE00 + 16'(i)]},
                        {8'd0, 8'(i) + 8'h40});
        cpu_rd_addr = 16'hFF46;
        #1;
        checkOutput("echo_reg", {8'd0, cpu_rd_data}, 16'h00E1);
        @(negedge clk);

        // Reset between byte 79 (edge 324) and byte 80 (edge 328)
        cpuWrite(16'hFF46, 8'hC0);
        repeat (325) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_active", {15'd0, dma_active}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cpu_rd_addr = 16'hFF46;
        #1;
        checkOutput("abort_reg", {8'd0, cpu_rd_data}, 16'h00FF);
        for (int i = 0; i < 160; i++)
            checkOutput($sformatf("abort_fe%0h", i), {8'd0, mem[16'hFE00 + 16'(i)]},
                        (i < 80) ? {8'd0, 8'(i) ^ 8'h5A} : {8'd0, 8'(i) + 8'h40});
        @(negedge clk);
        cpuWrite(16'hFF46, 8'hC0);
        waitIdle(len);
        checkOutput("post_len", 16'(len), 16'd644);
        checkOutput("post_fe9f", {8'd0, mem[16'hFE9F]}, 16'h00C5);

        // Idle pass-through
        applyStimulus(1'b1, 16'hC123, 8'hA5, 16'hC123);
        #1;
        checkOutput("idle_wen", {15'd0, mem_wen}, 16'h0001);
        @(negedge clk);
        cpu_wen = 1'b0;
        #1;
        checkOutput("idle_rd", {8'd0, cpu_rd_data}, 16'h00A5);
        checkOutput("idle_raddr", mem_r_addr, 16'hC123);
        checkOutput("idle_ff46mem", {8'd0, mem[16'hFF46]}, 16'h0077);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
